// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional prefetch line is enabled with the IFETCH_PREFETCH_EN macro.
package ifetch_pkg;

  localparam int INSTR_W   = 32;
  localparam int HALF_W    = 16;
  // Tags are stored zero-extended to this width so one struct serves any PC_W up to 32.
  localparam int TAG_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [INSTR_W-1:0]   data;
  } line_t;

endpackage

// File: rtl/ifetch_line.sv
// Tagged 32-bit line register with a load port, an invalidate port and
// LOOKUPS independent hit comparators.
module ifetch_line
  import ifetch_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int LOOKUPS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_en,
  input  logic [PC_W-1:0]               load_tag,
  input  logic [INSTR_W-1:0]            load_data,
  input  logic                          clr_en,
  input  logic [LOOKUPS-1:0][PC_W-1:0]  lookup_pc,
  output logic [LOOKUPS-1:0]            hit,
  output logic [INSTR_W-1:0]            line_data
);

  line_t line_q;
  line_t line_d;

  // A load wins over an invalidate so a refill landing on the same edge is kept.
  always_comb begin
    line_d = line_q;
    if (load_en) begin
      line_d.valid = 1'b1;
      line_d.tag   = TAG_MAX_W'(load_tag);
      line_d.data  = load_data;
    end else if (clr_en) begin
      line_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  for (genvar gi = 0; gi < LOOKUPS; gi++) begin : g_cmp
    assign hit[gi] = line_q.valid && (line_q.tag == TAG_MAX_W'(lookup_pc[gi]));
  end

  assign line_data = line_q.data;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: builds 32-bit instructions from two 16-bit memory
// transfers into a tagged line; IFETCH_PREFETCH_EN adds a next-line prefetch buffer.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    cpu_pc,
  output logic [INSTR_W-1:0] cpu_instr,
  output logic               cpu_stall,
  output logic               mem_req,
  output logic [PC_W:0]      mem_addr,
  input  logic               mem_ack,
  input  logic [HALF_W-1:0]  mem_rdata
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W:0]      mem_addr_q, mem_addr_d;
  logic [HALF_W-1:0]  lo_half_q, lo_half_d;

  logic               fill_done;
  logic [INSTR_W-1:0] fill_data;
  logic               any_hit;
  logic               main_hit;
  logic [INSTR_W-1:0] main_data;
  logic               main_load;
  logic [PC_W-1:0]    main_load_tag;
  logic [INSTR_W-1:0] main_load_data;

  assign fill_data = {mem_rdata, lo_half_q};

  ifetch_line #(
    .PC_W    (PC_W),
    .LOOKUPS (1)
  ) u_main_line (
    .clk       (clk),
    .rst       (rst),
    .load_en   (main_load),
    .load_tag  (main_load_tag),
    .load_data (main_load_data),
    .clr_en    (1'b0),
    .lookup_pc (cpu_pc),
    .hit       (main_hit),
    .line_data (main_data)
  );

`ifdef IFETCH_PREFETCH_EN
  logic               to_pf_q, to_pf_d;
  logic [PC_W-1:0]    next_pc;
  logic [1:0]         pf_hit;
  logic [INSTR_W-1:0] pf_data;
  logic               demand_fill;
  logic               pf_fill;
  logic               promote;

  assign next_pc = cpu_pc + PC_W'(1);

  // Lookup 0 serves the core; lookup 1 asks whether the next line is already buffered.
  ifetch_line #(
    .PC_W    (PC_W),
    .LOOKUPS (2)
  ) u_pf_line (
    .clk       (clk),
    .rst       (rst),
    .load_en   (pf_fill),
    .load_tag  (fetch_pc_q),
    .load_data (fill_data),
    .clr_en    (promote),
    .lookup_pc ({next_pc, cpu_pc}),
    .hit       (pf_hit),
    .line_data (pf_data)
  );

  assign demand_fill = fill_done && !to_pf_q;
  assign pf_fill     = fill_done && to_pf_q;
  // A demand refill owns the main line on its completing edge; promotion retries next cycle.
  assign promote     = pf_hit[0] && !main_hit && !demand_fill;

  assign main_load      = demand_fill || promote;
  assign main_load_tag  = demand_fill ? fetch_pc_q : cpu_pc;
  assign main_load_data = demand_fill ? fill_data : pf_data;

  assign any_hit   = main_hit || pf_hit[0];
  assign cpu_instr = (pf_hit[0] && !main_hit) ? pf_data : main_data;
`else
  assign main_load      = fill_done;
  assign main_load_tag  = fetch_pc_q;
  assign main_load_data = fill_data;

  assign any_hit   = main_hit;
  assign cpu_instr = main_data;
`endif

  assign cpu_stall = !any_hit;
  assign mem_req   = (state_q != IDLE);
  assign mem_addr  = mem_addr_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    lo_half_d  = lo_half_q;
    fill_done  = 1'b0;
`ifdef IFETCH_PREFETCH_EN
    to_pf_d    = to_pf_q;
`endif
    case (state_q)
      IDLE: begin
        if (!any_hit) begin
          fetch_pc_d = cpu_pc;
          mem_addr_d = {cpu_pc, 1'b0};
          state_d    = LO;
`ifdef IFETCH_PREFETCH_EN
          to_pf_d    = 1'b0;
        end else if (!pf_hit[1]) begin
          // On a hit the line in use is cpu_pc, so the sequential successor is cpu_pc+1.
          fetch_pc_d = next_pc;
          mem_addr_d = {next_pc, 1'b0};
          state_d    = LO;
          to_pf_d    = 1'b1;
`endif
        end
      end
      LO: begin
        if (mem_ack) begin
          lo_half_d  = mem_rdata;
          mem_addr_d = {fetch_pc_q, 1'b1};
          state_d    = HI;
        end
      end
      HI: begin
        if (mem_ack) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      mem_addr_q <= '0;
      lo_half_q  <= '0;
`ifdef IFETCH_PREFETCH_EN
      to_pf_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      lo_half_q  <= lo_half_d;
`ifdef IFETCH_PREFETCH_EN
      to_pf_q    <= to_pf_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a memory responder with configurable wait
// states, a bus-level model of the buffered line, and directed scenarios.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_pc = 16'h0000;
  logic [31:0] cpu_instr;
  logic        cpu_stall;
  logic        mem_req;
  logic [16:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;

  int tests = 0;
  int fails = 0;
  int wait_states = 0;
  int wait_cnt = 0;

  logic [16:0] done_q[$];

  // Model: the instruction held is the last LO/HI pair completed on the bus.
  logic        m_valid = 1'b0;
  logic [15:0] m_tag = 16'h0000;
  logic        m_lo_seen = 1'b0;
  logic [16:0] m_lo_addr = 17'h0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [16:0] prev_addr = 17'h0;

  instr_fetch #(.PC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_pc    (cpu_pc),
    .cpu_instr (cpu_instr),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_half(input logic [16:0] a);
    if (a == 17'h00000) return 16'h1234;
    if (a == 17'h00001) return 16'hABCD;
    return 16'(a * 17'd40503) ^ 16'h5A5A;
  endfunction

  function automatic logic [31:0] golden(input logic [15:0] pc);
    return {mem_half({pc, 1'b1}), mem_half({pc, 1'b0})};
  endfunction

  function automatic logic [16:0] q_at(input int i);
    if (i < done_q.size()) return done_q[i];
    return 17'bx;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: ack after wait_states idle cycles; a seen ack ends the transfer.
  always @(negedge clk) begin
    if (mem_ack) wait_cnt = 0;
    mem_rdata = mem_half(mem_addr);
    if (!mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= wait_states) begin
      mem_ack = 1'b1;
    end else begin
      mem_ack = 1'b0;
      wait_cnt++;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_stall", 32'(cpu_stall), 32'd1);
      check("rst_instr", cpu_instr, 32'd0);
      m_valid   = 1'b0;
      m_lo_seen = 1'b0;
      prev_req  = 1'b0;
      prev_ack  = 1'b0;
    end else begin
      if (prev_req && prev_ack) begin
        done_q.push_back(prev_addr);
        $display("[TB] xfer addr=%05h data=%04h", prev_addr, mem_half(prev_addr));
        if (!prev_addr[0]) begin
          m_lo_seen = 1'b1;
          m_lo_addr = prev_addr;
        end else if (m_lo_seen && m_lo_addr == {prev_addr[16:1], 1'b0}) begin
          m_valid   = 1'b1;
          m_tag     = prev_addr[16:1];
          m_lo_seen = 1'b0;
        end
      end else if (prev_req) begin
        check("req_hold", 32'(mem_req), 32'd1);
        check("addr_hold", 32'(mem_addr), 32'(prev_addr));
      end
`ifndef IFETCH_PREFETCH_EN
      check("stall_model", 32'(cpu_stall), 32'(!(m_valid && m_tag == cpu_pc)));
`endif
      if (!cpu_stall) check("instr_model", cpu_instr, golden(cpu_pc));
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
    end
  end

  task automatic measure_stall(output int n);
    n = 0;
    while (cpu_stall && n < 200) begin
      n++;
      @(negedge clk);
      #3;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int idx;
    int reqs;
    int stalls;
    int k;

    repeat (3) @(negedge clk);
    #1;
    check("reset_stall", 32'(cpu_stall), 32'd1);
    check("reset_instr", cpu_instr, 32'd0);
    check("reset_req", 32'(mem_req), 32'd0);
    check("reset_addr", 32'(mem_addr), 32'd0);
    $display("[TB] reset values checked");

`ifndef IFETCH_PREFETCH_EN
    // First fill after reset, zero-wait memory.
    @(negedge clk);
    rst = 1'b1;
    #3;
    idx = done_q.size();
    measure_stall(n);
    check("first_miss_stall", 32'(n), 32'd3);
    check("first_instr", cpu_instr, 32'hABCD1234);
    check("first_addr_lo", 32'(q_at(idx)), 32'h00000);
    check("first_addr_hi", 32'(q_at(idx + 1)), 32'h00001);
    $display("[TB] first fill: stall=%0d instr=%h", n, cpu_instr);

    // Hit: holding the PC must not request memory or stall.
    reqs = 0;
    stalls = 0;
    repeat (8) begin
      @(negedge clk);
      #3;
      reqs += 32'(mem_req);
      stalls += 32'(cpu_stall);
    end
    check("hit_no_req", 32'(reqs), 32'd0);
    check("hit_no_stall", 32'(stalls), 32'd0);
    $display("[TB] hit hold: reqs=%0d stalls=%0d", reqs, stalls);

    // Two wait states per transfer.
    @(negedge clk);
    wait_states = 2;
    cpu_pc = 16'h0005;
    idx = done_q.size();
    #3;
    measure_stall(n);
    check("wait_miss_stall", 32'(n), 32'd7);
    check("wait_instr", cpu_instr, golden(16'h0005));
    check("wait_addr_lo", 32'(q_at(idx)), 32'h0000A);
    check("wait_addr_hi", 32'(q_at(idx + 1)), 32'h0000B);
    $display("[TB] wait states: stall=%0d instr=%h", n, cpu_instr);

    // Jump during LO: the old line completes, then the new one is fetched.
    @(negedge clk);
    wait_states = 0;
    cpu_pc = 16'h0010;
    idx = done_q.size();
    @(negedge clk);
    #1;
    check("jump_lo_req", 32'(mem_req), 32'd1);
    check("jump_lo_addr", 32'(mem_addr), 32'h00020);
    cpu_pc = 16'h0040;
    #2;
    measure_stall(n);
    check("jump_stall", 32'(n), 32'd5);
    check("jump_instr", cpu_instr, golden(16'h0040));
    check("jump_addr0", 32'(q_at(idx)), 32'h00020);
    check("jump_addr1", 32'(q_at(idx + 1)), 32'h00021);
    check("jump_addr2", 32'(q_at(idx + 2)), 32'h00080);
    check("jump_addr3", 32'(q_at(idx + 3)), 32'h00081);
    $display("[TB] jump: stall=%0d instr=%h", n, cpu_instr);

    // Asynchronous reset while HI is pending.
    @(negedge clk);
    wait_states = 2;
    cpu_pc = 16'h0100;
    #3;
    k = 0;
    while (!(mem_req && mem_addr == 17'h00201) && k < 50) begin
      @(negedge clk);
      #3;
      k++;
    end
    check("reach_hi", 32'(k < 50), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_req", 32'(mem_req), 32'd0);
    check("async_rst_stall", 32'(cpu_stall), 32'd1);
    check("async_rst_instr", cpu_instr, 32'd0);
    repeat (2) @(negedge clk);
    wait_states = 0;
    rst = 1'b1;
    #3;
    measure_stall(n);
    check("refetch_stall", 32'(n), 32'd3);
    check("refetch_instr", cpu_instr, golden(16'h0100));
    $display("[TB] async reset: refetch stall=%0d instr=%h", n, cpu_instr);
`else
    // Sequential run across the address wrap with prefetch.
    @(negedge clk);
    cpu_pc = 16'hFFFE;
    rst = 1'b1;
    #3;
    measure_stall(n);
    check("pf_first_stall", 32'(n), 32'd3);
    check("pf_first_instr", cpu_instr, golden(16'hFFFE));
    idx = done_q.size();
    stalls = 0;
    repeat (6) begin
      @(negedge clk);
      #3;
      stalls += 32'(cpu_stall);
    end
    @(negedge clk);
    cpu_pc = 16'hFFFF;
    #3;
    stalls += 32'(cpu_stall);
    check("pf_ffff_instr", cpu_instr, golden(16'hFFFF));
    repeat (6) begin
      @(negedge clk);
      #3;
      stalls += 32'(cpu_stall);
    end
    @(negedge clk);
    cpu_pc = 16'h0000;
    #3;
    stalls += 32'(cpu_stall);
    check("pf_wrap_instr", cpu_instr, 32'hABCD1234);
    repeat (6) begin
      @(negedge clk);
      #3;
      stalls += 32'(cpu_stall);
    end
    check("pf_no_stall", 32'(stalls), 32'd0);
    check("pf_addr0", 32'(q_at(idx)), 32'h1FFFE);
    check("pf_addr1", 32'(q_at(idx + 1)), 32'h1FFFF);
    check("pf_addr2", 32'(q_at(idx + 2)), 32'h00000);
    check("pf_addr3", 32'(q_at(idx + 3)), 32'h00001);
    $display("[TB] prefetch wrap: stalls=%0d", stalls);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit between the 16-bit program memory and the CPU core. Assembles each 32-bit instruction from two consecutive 16-bit program-memory halfwords over a req/ack handshake, holds it in a tagged line buffer, and presents it on the core's 32-bit instruction input. Asserts a stall toward the core while the instruction for the current program address is unavailable.

## Interface
- `PC_W`, 16, program-address width in instructions; memory address width is `PC_W+1`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_pc` in `PC_W`: instruction address from the core (`e_prog_addr`).
- `cpu_instr` out 32: instruction for `cpu_pc`, valid when `cpu_stall`=0 (drives `e_instr`).
- `cpu_stall` out 1: high while `cpu_instr` does not correspond to `cpu_pc`.
- `mem_req` out 1: transfer request to program memory.
- `mem_addr` out `PC_W+1`: halfword address, `{fetch_pc, half}`.
- `mem_ack` in 1: transfer completes on a rising edge with `mem_req`=1 and `mem_ack`=1.
- `mem_rdata` in 16: read data, sampled on the completing edge.

## Operation
- Halfword order: `{fetch_pc,0}` is `instr[15:0]`; `{fetch_pc,1}` is `instr[31:16]`.
- Line buffer: `valid`, `tag[PC_W-1:0]`, `data[31:0]`.
  - Hit = `valid && tag==cpu_pc`.
  - `cpu_stall = !hit`, combinational.
  - `cpu_instr = data`, regardless of hit.
- FSM states:
  - IDLE: on miss, latch `fetch_pc<=cpu_pc` and go to LO.
  - LO: `mem_req`=1, addr `{fetch_pc,0}`. On ack, store low half and go to HI.
  - HI: `mem_req`=1, addr `{fetch_pc,1}`. On ack, write `data`, set `tag<=fetch_pc`, `valid<=1`, go to IDLE.
  - In IDLE: `mem_req`=0, `mem_addr` holds its last value.
- `mem_req` and `mem_addr` are stable from assertion until ack. A transfer is never withdrawn.
- `cpu_pc` changes during LO/HI (jump):
  - The in-flight transfer completes.
  - At the end of HI the line is still written with `fetch_pc`.
  - FSM returns to IDLE and the miss re-triggers next cycle.
  - A jump during LO does not shortcut; both halves are fetched.
- `valid` clears only on reset. The buffer is overwritten only on a completed HI.
- Address wrap: `fetch_pc+1` (prefetch) wraps modulo 2^`PC_W`; 0xFFFF+1 = 0x0000.

## Timing
- Reset values:
  - `valid`=0, `tag`=0, `data`=0, state IDLE, `mem_addr`=0, `mem_req`=0.
  - Therefore `cpu_instr`=0 and `cpu_stall`=1.
- Reset assertion mid-transfer drops `mem_req` immediately (asynchronous). Memory must tolerate an abandoned request.
- First request: `mem_req` rises on the first edge after reset deassertion where a miss is seen in IDLE.
- Miss penalty with zero-wait memory (`mem_ack` tied 1):
  - Miss seen at edge n.
  - LO completes at n+1, HI completes at n+2.
  - `cpu_stall`=0 after n+2, i.e. 3 stall cycles.
- Each wait cycle on `mem_ack` adds one cycle.
- Hit latency: 0 cycles (combinational).

## Configuration
- `IFETCH_PREFETCH_EN` defined:
  - Adds a second tagged buffer (prefetch line).
  - From IDLE with a hit and no prefetch line for `tag+1`, the FSM fetches `tag+1` (LO/HI) into the prefetch line.
  - When `cpu_pc` matches the prefetch tag, `cpu_stall`=0 and `cpu_instr` comes from the prefetch line. The next edge promotes it to the main line and invalidates the prefetch line.
  - A demand miss during a prefetch waits for the prefetch to finish; the demand fetch then has priority.
  - Sequential code with zero-wait memory runs stall-free after the first two instructions.
- `IFETCH_PREFETCH_EN` undefined: single line, fetch only on miss.

## Structure
- Package `ifetch_pkg` holds:
  - FSM state enum (IDLE, LO, HI).
  - `INSTR_W`=32 and `HALF_W`=16.
  - Line-buffer struct: `valid`, `tag`, `data`.
- Sub-module `ifetch_line`: a tagged 32-bit line register with a hit comparator and load port. Instantiated once, or twice with `IFETCH_PREFETCH_EN`.

## Test plan
- Reset, `mem_ack`=1, `cpu_pc`=0x0000, mem[0]=0x1234, mem[1]=0xABCD:
  - `mem_addr` sequence 0x00000 then 0x00001.
  - `cpu_stall` high for 3 cycles, then `cpu_instr`=0xABCD1234.
- Hit: hold `cpu_pc` after the fill → no further `mem_req`, `cpu_stall`=0 every cycle.
- Wait states: `mem_ack` low 2 cycles per transfer → `mem_req`/`mem_addr` stable throughout, 7 stall cycles, correct data.
- Jump mid-fetch: `cpu_pc` 0x0010→0x0040 during LO:
  - Line 0x0010 completes.
  - Then addrs 0x00080/0x00081 are fetched.
  - `cpu_stall` clears only with tag 0x0040.
- Async reset asserted during HI → `mem_req`=0 immediately, `cpu_stall`=1, `cpu_instr`=0; refetch after release.
- With `IFETCH_PREFETCH_EN`, `cpu_pc` stepping 0xFFFE,0xFFFF,0x0000 with zero-wait memory:
  - Prefetch of 0xFFFF and then 0x0000 (wrap, addrs 0x00000/0x00001).
  - No stall after the initial 3-cycle miss.
